uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
- REQ-001 Parameter DEPTH, default 16, meaning FIFO entries; it SHALL be a power of two, 2..256.
- REQ-002 Parameter CW, default 16, meaning width of the bit-period counter and of bit_width.
- REQ-003 Port clk, input, 1, meaning the single system clock; all state SHALL change on its rising edge only.
- REQ-004 Port rst, input, 1, meaning reset; it SHALL be synchronous and active-high.
- REQ-005 Port rx, input, 1, meaning the UART line from the pin; it is asynchronous to clk and idles high.
- REQ-006 Port bit_width, input, CW, meaning clock cycles per bit (200 MHz / 115200 = 1736); it is static while a frame is being received.
- REQ-007 Port rd_en, input, 1, meaning a one-cycle pop request from the memory-mapped RX data register read.
- REQ-008 Port rd_data, output, 8, meaning the popped byte.
- REQ-009 Port empty, output, 1, meaning the FIFO holds no bytes.
- REQ-010 Port count, output, log2(DEPTH)+1, meaning the number of bytes held.
- REQ-011 Port overrun, output, 1, meaning sticky: a byte was lost because the FIFO was full.
- REQ-012 Port frame_err, output, 1, meaning sticky: a stop bit was sampled low.
- REQ-013 Port clr_err, input, 1, meaning a one-cycle pulse that clears overrun and frame_err.

Function
- REQ-014 rx SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value rxs.
- REQ-015 Receiver FSM states SHALL be IDLE, START, DATA, STOP.
- REQ-016 IDLE: on a falling edge of rxs (previous 1, current 0), load counter = bit_width>>1 and go to START.
- REQ-017 Counter SHALL decrement by 1 per cycle in START, DATA and STOP; a state's sample point is the cycle the counter equals 0.
- REQ-018 START sample: rxs=1 means a false start, so go to IDLE with no push. rxs=0 means load counter = bit_width-1, bit index = 0, and go to DATA.
- REQ-019 DATA: at each sample point, shift rxs into the byte LSB first and reload counter = bit_width-1; after the 8th bit, go to STOP.
- REQ-020 STOP sample: rxs=1 means push the byte and go to IDLE. rxs=0 means discard the byte, set frame_err, and go to IDLE.
- REQ-021 After a frame error, IDLE SHALL require rxs to return to 1 before a new falling edge is accepted, so a held break yields exactly one frame_err.
- REQ-022 bit_width values below 4 SHALL be treated as 4.
- REQ-023 Pop: when rd_en=1 and empty=0, rd_data SHALL present the head byte on the next cycle (1-cycle latency, matching BRAM reads), and the read pointer advances.
- REQ-024 rd_en with empty=1 SHALL be ignored; rd_data holds its last value.
- REQ-025 Push on full without a same-cycle pop: the byte is dropped and overrun is set; FIFO contents are unchanged.
- REQ-026 Push and pop in the same cycle: both SHALL take effect, even when full (the pop frees the slot), and count is unchanged.
- REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL equal write minus read, computed at log2(DEPTH)+1 bits.
- REQ-028 If clr_err coincides with a new error event, the flag SHALL end set (set wins).
- REQ-029 A pushed byte SHALL be visible (empty=0, count incremented) on the cycle after the STOP sample.

Reset
- REQ-030 When rst=1, the following SHALL hold on the next edge: FSM = IDLE, counter = 0, pointers = 0, count = 0, empty = 1, rd_data = 0, overrun = 0, frame_err = 0, synchronizer flops = 1.
- REQ-031 A reset during a frame SHALL abandon that frame, push nothing, and set no flags.
- REQ-032 The same frame's remaining bits after reset SHALL be treated as line activity; a low data bit may start a new frame.

Verification
- REQ-033 bit_width=1736, send 0xA5 with 8N1 -> empty=0 and count=1 within 10*1736+4 cycles; rd_en pulse -> rd_data=0xA5 next cycle, empty=1.
- REQ-034 Send a 0-pulse of 600 cycles on an idle line -> no push, frame_err=0, FSM back in IDLE.
- REQ-035 DEPTH=16, send 17 bytes 0x00..0x10 with no reads -> count=16, overrun=1; 16 reads return 0x00..0x0F in order.
- REQ-036 Full FIFO, rd_en asserted on the same cycle as the STOP-sample push -> count stays 16, overrun=0, last byte is retained.
- REQ-037 Hold rx=0 for 30*1736 cycles, then release -> exactly one frame_err, no push; clr_err -> frame_err=0.
- REQ-038 Assert rst for 1 cycle in the middle of the DATA state of byte 0x3C -> no push, all outputs at reset values; next clean byte 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO with a one-cycle-latency registered read port.
// Sticky overrun/frame-error flags; a clear pulse loses to a coincident new error.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic [CW-1:0]            bit_width,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic            sync1, rxs, rxs_prev;
    logic [CW-1:0]   cnt, bw_eff;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            fall, cnt_zero, push, stop_err;
    logic            full, do_pop, do_push;
    logic [7:0]      mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            sync1    <= rx;
            rxs      <= sync1;
            rxs_prev <= rxs;
        end
    end

    assign bw_eff   = (bit_width < CW'(4)) ? CW'(4) : bit_width;
    assign fall     = rxs_prev & ~rxs;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: a default assignment first keeps combinational processes free of latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall) state_next = START;
            START:   if (cnt_zero) state_next = rxs ? IDLE : DATA;
            DATA:    if (cnt_zero && bit_idx == 3'd7) state_next = STOP;
            STOP:    if (cnt_zero) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        push     = (state == STOP) && cnt_zero && rxs;
        stop_err = (state == STOP) && cnt_zero && !rxs;
    end

    // A held break leaves rxs low in IDLE, so no new falling edge until the line recovers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE:  if (fall) cnt <= bw_eff >> 1;
                START: begin
                    if (cnt_zero) begin
                        cnt     <= bw_eff - CW'(1);
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        cnt     <= bw_eff - CW'(1);
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                STOP:    if (!cnt_zero) cnt <= cnt - CW'(1);
                default: cnt <= '0;
            endcase
        end
    end

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = rd_en & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: the storage array is deliberately not reset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data   <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            overrun   <= (overrun & ~clr_err) | (push & full & ~do_pop);
            frame_err <= (frame_err & ~clr_err) | stop_err;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: a cycle-accurate frame model built from sample-point arithmetic
// and a byte queue is compared with the DUT every cycle, plus hand-computed checks.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = 16;
    localparam int AW    = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rx = 1'b1;
    logic           rd_en = 1'b0;
    logic           clr_err = 1'b0;
    logic [CW-1:0]  bit_width = 16'd16;
    logic [7:0]     rd_data;
    logic           empty, overrun, frame_err;
    logic [AW:0]    count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .rx(rx), .bit_width(bit_width), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(rd_data), .empty(empty), .count(count),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame begins when the synchronized line falls; its sample points sit at
    // half a bit period plus whole bit periods later. Bytes live in a plain queue.
    int          cyc = 0, t0 = 0, bwm = 4, hm = 2, d = 0, k = 0;
    bit          busy_m = 0, push_m = 0, ferr_ev = 0;
    logic        s1_m = 1, rxs_m = 1, prev_m = 1;
    logic [7:0]  byte_m = '0, rd_exp = '0;
    logic [7:0]  q_m[$];
    bit          ovr_m = 0, ferr_m = 0;
    int          ferr_events = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            s1_m = 1; rxs_m = 1; prev_m = 1; busy_m = 0;
            q_m.delete(); rd_exp = '0; ovr_m = 0; ferr_m = 0;
        end else begin
            push_m = 0; ferr_ev = 0;
            if (busy_m) begin
                d = cyc - (t0 + hm + 1);
                if (d >= 0 && d % bwm == 0) begin
                    k = d / bwm;
                    if (k == 0) begin
                        if (rxs_m) busy_m = 0;
                    end else if (k <= 8) begin
                        byte_m[k-1] = rxs_m;
                    end else begin
                        if (rxs_m) push_m = 1;
                        else begin ferr_ev = 1; ferr_events++; end
                        busy_m = 0;
                    end
                end
            end else if (prev_m && !rxs_m) begin
                busy_m = 1; t0 = cyc;
                bwm = (bit_width < 4) ? 4 : int'(bit_width);
                hm = bwm / 2;
            end
            if (clr_err) begin ovr_m = 0; ferr_m = 0; end
            if (rd_en && q_m.size() > 0) rd_exp = q_m.pop_front();
            if (push_m) begin
                if (q_m.size() < DEPTH) q_m.push_back(byte_m);
                else ovr_m = 1;
            end
            if (ferr_ev) ferr_m = 1;
            prev_m = rxs_m; rxs_m = s1_m; s1_m = rx;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("count", count, q_m.size());
            check("empty", empty, q_m.size() == 0);
            check("rd_data", rd_data, rd_exp);
            check("overrun", overrun, ovr_m);
            check("frame_err", frame_err, ferr_m);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input int pop_at,
                              input int rst_at, input bit rand_rd);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int m = 0; m < 10 * per; m++) begin
            @(negedge clk);
            if (rst_at >= 0 && m == rst_at + 1) begin
                check("rst_count", count, 0);
                check("rst_empty", empty, 1);
                check("rst_rd_data", rd_data, 0);
                check("rst_overrun", overrun, 0);
                check("rst_frame_err", frame_err, 0);
            end
            rx    = bits[m / per];
            rd_en = (m == pop_at) || (rand_rd && $urandom_range(63) == 0);
            rst   = (m == rst_at);
        end
        @(negedge clk);
        rd_en = 1'b0; rst = 1'b0; rx = 1'b1;
    endtask

    task automatic pop_one(output logic [7:0] dat);
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        dat = rd_data;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
    endtask

    logic [7:0] dat;
    int fe0, per;

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("init_count", count, 0);
        check("init_empty", empty, 1);
        check("init_rd_data", rd_data, 0);

        // Full-rate frame at 115200 baud from 200 MHz
        bit_width = 16'd1736;
        send_frame(8'hA5, 1736, -1, -1, 0);
        check("a5_count", count, 1);
        check("a5_empty", empty, 0);
        pop_one(dat);
        check("a5_data", dat, 8'hA5);
        check("a5_empty_after", empty, 1);

        // Short glitch shorter than half a bit: false start
        repeat (600) begin @(negedge clk); rx = 1'b0; end
        idle(1200);
        check("glitch_count", count, 0);
        check("glitch_ferr", frame_err, 0);
        check("glitch_model_idle", busy_m, 0);

        // bit_width below 4 behaves as 4
        bit_width = 16'd2;
        send_frame(8'hC3, 4, -1, -1, 0);
        idle(4);
        pop_one(dat);
        check("clamp_data", dat, 8'hC3);

        // Overfill: 17 bytes into 16 slots
        bit_width = 16'd8;
        for (int i = 0; i < 17; i++) send_frame(8'(i), 8, -1, -1, 0);
        idle(4);
        check("fill_count", count, 16);
        check("fill_overrun", overrun, 1);
        pulse_clr();
        check("clr_overrun", overrun, 0);

        // Push while full with a pop on the stop-sample cycle
        send_frame(8'h77, 8, 3 + (8 >> 1) + 9 * 8, -1, 0);
        idle(2);
        check("full_pp_count", count, 16);
        check("full_pp_overrun", overrun, 0);
        check("full_pp_pop", rd_data, 8'h00);
        for (int i = 1; i < 16; i++) begin
            pop_one(dat);
            check("drain_data", dat, i);
        end
        pop_one(dat);
        check("drain_last", dat, 8'h77);
        check("drain_empty", empty, 1);

        // Held break: exactly one frame error
        bit_width = 16'd16;
        fe0 = ferr_events;
        repeat (30 * 16) begin @(negedge clk); rx = 1'b0; end
        idle(20 * 16);
        check("break_ferr", frame_err, 1);
        check("break_events", ferr_events - fe0, 1);
        check("break_count", count, 0);
        pulse_clr();
        check("break_clr", frame_err, 0);

        // Reset in the middle of a frame's data bits
        send_frame(8'h11, 16, -1, -1, 0);
        check("pre_rst_count", count, 1);
        send_frame(8'h3C, 16, -1, 3 + 8 + 16 * 3, 0);
        idle(200);
        for (int g = 0; g <= DEPTH && q_m.size() > 0; g++) pop_one(dat);
        pulse_clr();
        send_frame(8'h5A, 16, -1, -1, 0);
        idle(4);
        pop_one(dat);
        check("post_rst_data", dat, 8'h5A);

        // Randomized traffic with random pops and occasional clears
        for (int i = 0; i < 30; i++) begin
            per = $urandom_range(4, 20);
            bit_width = CW'(per);
            send_frame(8'($urandom), per, -1, -1, 1);
            if ($urandom_range(7) == 0) pulse_clr();
            idle($urandom_range(0, 5));
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
